sfilt_seq: RTL and testbench

SFILT_SEQ -- requirements
Module: sfilt_seq

---
 rtl/sfilt_seq.sv | 171 +++++++++++++++++
 tb/tb_sfilt_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfilt_seq.sv
// sfilt_seq -- command sequencer for an external serial FIR filter.
//
// Each accepted sample is stored in a circular history of NTAPS entries.
// The block then issues one command per issue slot to the serial filter:
//   first-mult (c[0]*x[n]), NTAPS-1 mult-accumulates (c[k]*x[n-k]),
//   an optional shift/round, and a send-and-clear.
// It then waits for the filter's result and presents it on z with a
// one-cycle pushout strobe. CMD_GAP idle cycles separate consecutive commands.
//
// Build option: define SFILT_SEQ_ROUND_EN to include the shift/round
// command (NTAPS+2 commands per sample). When it is undefined the shift is
// skipped, shamt is unused, and each sample issues NTAPS+1 commands.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pushin, sample, ready sample input handshake (accepted on pushin & ready)
//   cfg_we/addr/data      coefficient write, honoured only in IDLE
//   shamt                 round shift amount, latched on sample acceptance
//   f_pushin/f_cmd/f_q/f_h  command stream to the serial filter
//   f_pushout, f_z        result from the serial filter
//   pushout, z            filter output strobe and held result
module sfilt_seq #(
  parameter int NTAPS   = 8,
  parameter int CMD_GAP = 0,
  parameter int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pushin,
  input  logic [31:0]   sample,
  output logic          ready,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic [6:0]    shamt,
  output logic          f_pushin,
  output logic [1:0]    f_cmd,
  output logic [31:0]   f_q,
  output logic [31:0]   f_h,
  input  logic          f_pushout,
  input  logic [31:0]   f_z,
  output logic          pushout,
  output logic [31:0]   z
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_MAC, S_SHIFT, S_FLUSH, S_WAIT, S_OUT
  } state_t;

  localparam logic [AW:0]   NT_W   = (AW+1)'(NTAPS);
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS-1);
  localparam logic [3:0]    GAP    = 4'(CMD_GAP);

  state_t        state, state_nx;
  logic [31:0]   hist [NTAPS];
  logic [31:0]   coef [NTAPS];
  logic [AW-1:0] wr_ptr, base, k, rd_idx;
  logic [AW:0]   rd_wide;
  logic [3:0]    gap_cnt;
  logic          accept, cfg_ok, issue_st, fire;

`ifdef SFILT_SEQ_ROUND_EN
  logic [6:0]    shamt_q;
`else
  logic          unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  assign ready    = (state == S_IDLE);
  assign pushout  = (state == S_OUT);
  assign accept   = pushin & ready;
  assign cfg_ok   = cfg_we & ready & ({1'b0, cfg_addr} < NT_W);
  assign issue_st = (state == S_FIRST) || (state == S_MAC) ||
                    (state == S_SHIFT) || (state == S_FLUSH);
  assign fire     = issue_st && (gap_cnt == 4'd0);

  // x[n-k] lives at (base - k) mod NTAPS; bias by NTAPS to stay non-negative.
  always_comb begin
    rd_wide = {1'b0, base} + NT_W - {1'b0, k};
    if (rd_wide >= NT_W) rd_wide = rd_wide - NT_W;
    rd_idx = rd_wide[AW-1:0];
  end

  always_comb begin
    state_nx = state;
    f_pushin = 1'b0;
    f_cmd    = 2'd0;
    f_q      = 32'd0;
    f_h      = 32'd0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_FIRST;
      S_FIRST: if (fire) begin
        f_pushin = 1'b1;
        f_cmd    = 2'd0;
        f_q      = hist[rd_idx];
        f_h      = coef[0];
        state_nx = S_MAC;
      end
      S_MAC: if (fire) begin
        f_pushin = 1'b1;
        f_cmd    = 2'd1;
        f_q      = hist[rd_idx];
        f_h      = coef[k];
        if (k == K_LAST) begin
`ifdef SFILT_SEQ_ROUND_EN
          state_nx = S_SHIFT;
`else
          state_nx = S_FLUSH;
`endif
        end
      end
`ifdef SFILT_SEQ_ROUND_EN
      S_SHIFT: if (fire) begin
        f_pushin = 1'b1;
        f_cmd    = 2'd2;
        f_h      = {25'b0, shamt_q};
        state_nx = S_FLUSH;
      end
`endif
      S_FLUSH: if (fire) begin
        f_pushin = 1'b1;
        f_cmd    = 2'd3;
        state_nx = S_WAIT;
      end
      S_WAIT:  if (f_pushout) state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      base    <= '0;
      k       <= '0;
      gap_cnt <= 4'd0;
      z       <= 32'd0;
`ifdef SFILT_SEQ_ROUND_EN
      shamt_q <= 7'd0;
`endif
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= 32'd0;
        coef[i] <= 32'd0;
      end
    end else begin
      state <= state_nx;
      // Write lands on the same edge as acceptance, so FIRST already sees it.
      if (cfg_ok) coef[cfg_addr] <= cfg_data;
      if (accept) begin
        hist[wr_ptr] <= sample;
        base         <= wr_ptr;
        wr_ptr       <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
        k            <= '0;
`ifdef SFILT_SEQ_ROUND_EN
        shamt_q      <= shamt;
`endif
      end
      if (fire) begin
        k       <= k + 1'b1;
        // No gap after send-and-clear: the next sample's first command
        // must follow acceptance by exactly one cycle.
        gap_cnt <= (state == S_FLUSH) ? 4'd0 : GAP;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      if (state == S_WAIT && f_pushout) z <= f_z;
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Testbench for sfilt_seq: randomized samples/coefficients against a
// convolution reference model, with a behavioural serial-filter model
// answering the command stream.
module tb_sfilt_seq;
  localparam int NT = 4;
  localparam int G  = 2;
  localparam int AW = $clog2(NT);
`ifdef SFILT_SEQ_ROUND_EN
  localparam int NCMD = NT + 2;
`else
  localparam int NCMD = NT + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n, pushin, ready, cfg_we, f_pushin, f_pushout, pushout;
  logic [31:0]   sample, cfg_data, f_q, f_h, f_z, z;
  logic [AW-1:0] cfg_addr;
  logic [6:0]    shamt;
  logic [1:0]    f_cmd;

  int n_chk = 0;
  int n_fail = 0;

  sfilt_seq #(.NTAPS(NT), .CMD_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .pushin(pushin), .sample(sample), .ready(ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .shamt(shamt),
    .f_pushin(f_pushin), .f_cmd(f_cmd), .f_q(f_q), .f_h(f_h),
    .f_pushout(f_pushout), .f_z(f_z), .pushout(pushout), .z(z)
  );

  always #5 clk = ~clk;

  // Serial filter model: 32-bit accumulator, answers send-and-clear after
  // a random 1..4 cycle latency.
  logic [31:0] acc, mdl_z, inj_z;
  logic        mdl_po, pend, inj_po;
  int          dly;
  assign f_pushout = mdl_po | inj_po;
  assign f_z       = inj_po ? inj_z : mdl_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 0; mdl_z <= 0; mdl_po <= 0; pend <= 0; dly <= 0;
    end else begin
      mdl_po <= 1'b0;
      if (pend) begin
        if (dly == 0) begin mdl_po <= 1'b1; pend <= 1'b0; end
        else dly <= dly - 1;
      end
      if (f_pushin) begin
        case (f_cmd)
          2'd0: acc <= f_q * f_h;
          2'd1: acc <= acc + f_q * f_h;
          2'd2: acc <= $signed(acc) >>> f_h[6:0];
          default: begin
            mdl_z <= acc; acc <= 0; pend <= 1'b1; dly <= $urandom_range(0, 3);
          end
        endcase
      end
    end
  end

  // Reference state: coefficients and the last NT accepted samples (newest first).
  logic [31:0] coef_m [NT];
  logic [31:0] hq [$];

  task automatic model_reset();
    for (int i = 0; i < NT; i++) coef_m[i] = 0;
    hq.delete();
    for (int i = 0; i < NT; i++) hq.push_back(0);
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1; cfg_addr = AW'(a); cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
    coef_m[a] = d;
  endtask

  // Process one sample. poke: bit0 = coef write while busy, bit1 = pushin
  // while busy, bit2 = stray f_pushout while busy.
  task automatic run_sample(input logic [31:0] s, input logic [6:0] sh,
                            input bit cw, input int ca, input logic [31:0] cd,
                            input int poke, output logic [31:0] zgot);
    logic [1:0]  ec [NCMD];
    logic [31:0] eq [NCMD];
    logic [31:0] eh [NCMD];
    logic [31:0] sum, y;
    int idx;
    bit done, exp_p;
    @(negedge clk);
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle got %b want 1", ready); end
    pushin = 1; sample = s; shamt = sh;
    if (cw) begin cfg_we = 1; cfg_addr = AW'(ca); cfg_data = cd; coef_m[ca] = cd; end
    hq.push_front(s);
    hq.delete(NT);
    sum = 0;
    for (int i = 0; i < NT; i++) begin
      ec[i] = (i == 0) ? 2'd0 : 2'd1;
      eq[i] = hq[i];
      eh[i] = coef_m[i];
      sum = sum + hq[i] * coef_m[i];
    end
`ifdef SFILT_SEQ_ROUND_EN
    ec[NT] = 2'd2; eq[NT] = 0; eh[NT] = {25'b0, sh};
    y = $signed(sum) >>> sh;
`else
    y = sum;
`endif
    ec[NCMD-1] = 2'd3; eq[NCMD-1] = 0; eh[NCMD-1] = 0;
    zgot = 32'hx;
    idx = 0;
    done = 0;
    @(negedge clk);
    for (int cyc = 1; cyc <= NCMD*(G+1) + 20 && !done; cyc++) begin
      pushin = 0; cfg_we = 0; inj_po = 0;
      if (cyc == 2 && poke[1]) begin pushin = 1; sample = $urandom; end
      if (cyc == 2 && poke[2]) begin inj_po = 1; inj_z = 32'hdeadbeef; end
      if (cyc == 3 && poke[0]) begin cfg_we = 1; cfg_addr = 0; cfg_data = 9; end
      exp_p = (idx < NCMD) && ((cyc - 1) % (G + 1) == 0);
      n_chk++;
      if (f_pushin !== exp_p) begin
        n_fail++; $display("FAIL f_pushin cyc %0d got %b want %b", cyc, f_pushin, exp_p);
      end
      if (exp_p) begin
        n_chk++;
        if (f_cmd !== ec[idx] || f_q !== eq[idx] || f_h !== eh[idx]) begin
          n_fail++;
          $display("FAIL cmd%0d got cmd=%0d q=%h h=%h want cmd=%0d q=%h h=%h",
                   idx, f_cmd, f_q, f_h, ec[idx], eq[idx], eh[idx]);
        end
        idx++;
      end
      if (pushout === 1'b1) begin
        done = 1; zgot = z;
        n_chk++;
        if (z !== y || idx != NCMD) begin
          n_fail++; $display("FAIL result got z=%h after %0d cmds want z=%h after %0d", z, idx, y, NCMD);
        end
      end
      n_chk++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_busy cyc %0d got %b want 0", cyc, ready); end
      @(negedge clk);
    end
    pushin = 0; cfg_we = 0; inj_po = 0;
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL timeout no pushout got 0 want 1"); end
    n_chk++;
    if (pushout !== 1'b0 || ready !== 1'b1 || z !== y) begin
      n_fail++; $display("FAIL after_out got po=%b rdy=%b z=%h want 0 1 %h", pushout, ready, z, y);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; pushin = 0; sample = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    shamt = 0; inj_po = 0; inj_z = 0;
    model_reset();
    #12;
    n_chk++;
    if (f_pushin !== 0 || f_cmd !== 0 || f_q !== 0 || f_h !== 0) begin
      n_fail++; $display("FAIL reset_cmd got %b %0d %h %h want 0 0 0 0", f_pushin, f_cmd, f_q, f_h);
    end
    n_chk++;
    if (pushout !== 0 || z !== 0) begin
      n_fail++; $display("FAIL reset_out got po=%b z=%h want 0 0", pushout, z);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
  endtask

  task automatic test_impulse();
    logic [31:0] zg;
    logic [31:0] exp_z [5];
    logic [31:0] imp [5];
    exp_z = '{1, 2, 3, 4, 0};
    imp   = '{1, 0, 0, 0, 0};
    for (int i = 0; i < NT; i++) cfg_write(i, i + 1);
    for (int j = 0; j < 5; j++) begin
      run_sample(imp[j], 0, 0, 0, 0, 0, zg);
      n_chk++;
      if (zg !== exp_z[j]) begin n_fail++; $display("FAIL impulse%0d got %h want %h", j, zg, exp_z[j]); end
    end
  endtask

  task automatic test_cfg_busy();
    logic [31:0] zg;
    run_sample(0, 0, 0, 0, 0, 7, zg);
    run_sample(1, 0, 0, 0, 0, 0, zg);
    n_chk++;
    if (zg !== 32'd1) begin n_fail++; $display("FAIL cfg_busy_impulse got %h want 1", zg); end
  endtask

  task automatic test_cmd_seq();
    logic [31:0] zg;
    run_sample(5, 7'd3, 0, 0, 0, 0, zg);
    run_sample(32'hffff_fff0, 7'd1, 1, 2, 32'd11, 0, zg);
  endtask

  task automatic test_random();
    logic [31:0] zg;
    for (int n = 0; n < 30; n++)
      run_sample($urandom, 7'($urandom_range(0, 40)), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, NT - 1), $urandom, $urandom_range(0, 7), zg);
  endtask

  task automatic test_reset_mid();
    logic [31:0] zg;
    @(negedge clk);
    pushin = 1; sample = 32'd77; shamt = 0;
    @(negedge clk);
    pushin = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++;
    if (f_pushin !== 0 || pushout !== 0 || z !== 0) begin
      n_fail++; $display("FAIL reset_mid got fp=%b po=%b z=%h want 0 0 0", f_pushin, pushout, z);
    end
    @(negedge clk); rst_n = 1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if (pushout !== 0 || f_pushin !== 0) begin
        n_fail++; $display("FAIL reset_abort cyc %0d got po=%b fp=%b want 0 0", c, pushout, f_pushin);
      end
    end
    for (int i = 0; i < NT; i++) cfg_write(i, i + 1);
    run_sample(1, 0, 0, 0, 0, 0, zg);
    n_chk++;
    if (zg !== 32'd1) begin n_fail++; $display("FAIL reset_impulse got %h want 1", zg); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_cfg_busy();
    test_cmd_seq();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
